truth_table_sequencer: RTL and testbench

//  Controller that exercises a combinational logic-function block (inputs A,B,C -> outputs F1..F4).
//  On start it walks every input combination, waits a settle time, and captures each output vector.
//  The result is a truth table held in a row store.

---
 rtl/tt_pkg.sv | 26 ++
 rtl/tt_row_store.sv | 43 ++++
 rtl/truth_table_sequencer.sv | 153 +++++++++++++++
 tb/tb_truth_table_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Package: tt_pkg
// Purpose: shared state encoding and sizing helper for the truth-table
//          sequencer and its row store.
// Contents:
//   ST_IDLE/ST_APPLY/ST_SAMPLE/ST_DONE  2-bit state codes
//   tt_state_t                          FSM state enum built on those codes
//   tt_rows(n_in)                       number of truth-table rows (2**n_in)
package tt_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        APPLY  = ST_APPLY,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } tt_state_t;

    function automatic int tt_rows(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_row_store.sv
// Module: tt_row_store
// Purpose: register file holding one captured output vector per input
//          combination; single write port, combinational read port.
// Ports:
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous active-low reset, clears every row
//   we       in   1       write enable
//   wr_idx   in   N_IN    row being written
//   wr_data  in   N_OUT   value written into row wr_idx
//   rd_idx   in   N_IN    row selected for readback
//   rd_row   out  N_OUT   contents of row rd_idx (combinational)
module tt_row_store
    import tt_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [N_IN-1:0]  wr_idx,
    input  logic [N_OUT-1:0] wr_data,
    input  logic [N_IN-1:0]  rd_idx,
    output logic [N_OUT-1:0] rd_row
);

    localparam int ROWS = tt_rows(N_IN);

    logic [N_OUT-1:0] rows [ROWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                rows[i] <= '0;
            end
        end else if (we) begin
            rows[wr_idx] <= wr_data;
        end
    end

    assign rd_row = rows[rd_idx];

endmodule

// File: rtl/truth_table_sequencer.sv
// Module: truth_table_sequencer
// Purpose: walks every input combination of a combinational function block,
//          holds each one for SETTLE cycles, captures the block's outputs and
//          stores them as a truth table.
// Ports:
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       begin a full scan (only honoured in IDLE)
//   abort     in   1       synchronous abort back to IDLE
//   abc_out   out  N_IN    vector driven to the function block (MSB = A)
//   f_in      in   N_OUT   outputs of the function block (bit0 = F1)
//   busy      out  1       high while applying/sampling rows
//   done      out  1       one-cycle pulse at the end of a complete scan
//   tt_valid  out  1       row store holds a complete scan
//   rd_idx    in   N_IN    readback row select
//   rd_row    out  N_OUT   stored row rd_idx (combinational)
module truth_table_sequencer
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  abc_out,
    input  logic [N_OUT-1:0] f_in,
    output logic             busy,
    output logic             done,
    output logic             tt_valid,
    input  logic [N_IN-1:0]  rd_idx,
    output logic [N_OUT-1:0] rd_row
);

    // Settle counter only has to reach SETTLE-1.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(tt_rows(N_IN) - 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(SETTLE - 1);

    tt_state_t       state;
    tt_state_t       state_next;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;

    logic load_first;
    logic advance;
    logic cnt_inc;
    logic we;
    logic set_valid;
    logic clr_valid;

    // State register plus the datapath registers it steers. abc_out is only
    // loaded on entry to APPLY, so it cannot change while a row is settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            abc_out  <= '0;
            tt_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (load_first) begin
                idx     <= '0;
                cnt     <= '0;
                abc_out <= '0;
            end else if (advance) begin
                idx     <= idx + 1'b1;
                cnt     <= '0;
                abc_out <= idx + 1'b1;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (load_first || clr_valid) begin
                tt_valid <= 1'b0;
            end else if (set_valid) begin
                tt_valid <= 1'b1;
            end
        end
    end

    // Next-state and control decode. Abort is applied last so it overrides
    // any start, row write or completion decided above it.
    always_comb begin
        state_next = state;
        load_first = 1'b0;
        advance    = 1'b0;
        cnt_inc    = 1'b0;
        we         = 1'b0;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = APPLY;
                    load_first = 1'b1;
                end
            end
            APPLY: begin
                if (cnt == LAST_CNT) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SAMPLE: begin
                we = 1'b1;
                // Explicit terminal compare; idx is never allowed to wrap.
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    state_next = APPLY;
                    advance    = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                set_valid  = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next = IDLE;
            load_first = 1'b0;
            advance    = 1'b0;
            cnt_inc    = 1'b0;
            we         = 1'b0;
            set_valid  = 1'b0;
            clr_valid  = (state != IDLE);
        end
    end

    assign busy = (state == APPLY) || (state == SAMPLE);
    assign done = (state == DONE) && !abort;

    tt_row_store #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wr_idx  (idx),
        .wr_data (f_in),
        .rd_idx  (rd_idx),
        .rd_row  (rd_row)
    );

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Testbench: tb_truth_table_sequencer
// Purpose: directed checks of the truth-table sequencer. dut1 uses SETTLE=1
//          with a combinational function model; dut3 uses SETTLE=3 with the
//          function fed through a two-cycle delay.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start1, abort1, busy1, done1, tt_valid1;
    logic [2:0] abc1, rd_idx1;
    logic [3:0] f_in1, rd_row1;
    int         fmode;

    logic       start3, abort3, busy3, done3, tt_valid3;
    logic [2:0] abc3, rd_idx3, d1, d2;
    logic [3:0] f_in3, rd_row3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    truth_table_sequencer #(.N_IN(3), .N_OUT(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .abc_out(abc1), .f_in(f_in1), .busy(busy1), .done(done1),
        .tt_valid(tt_valid1), .rd_idx(rd_idx1), .rd_row(rd_row1)
    );

    truth_table_sequencer #(.N_IN(3), .N_OUT(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .abc_out(abc3), .f_in(f_in3), .busy(busy3), .done(done3),
        .tt_valid(tt_valid3), .rd_idx(rd_idx3), .rd_row(rd_row3)
    );

    // mode 0: F1 = ~A & B, F2..F4 = 0; mode 1: {1, A, B, C}
    always_comb begin
        f_in1 = 4'b0000;
        if (fmode == 0) f_in1 = {3'b000, ~abc1[2] & abc1[1]};
        else            f_in1 = {1'b1, abc1};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= 3'b000;
            d2 <= 3'b000;
        end else begin
            d1 <= abc3;
            d2 <= d1;
        end
    end

    // F1 = ~A&B, F2 = B|C, F3 = A&C, F4 = A^B^C on the delayed vector
    always_comb f_in3 = {d2[2] ^ d2[1] ^ d2[0], d2[2] & d2[0], d2[1] | d2[0], ~d2[2] & d2[1]};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        $display("[TB] test_reset");
        checks++; if (abc1 !== 3'd0) begin failures++; $display("[TB] FAIL reset_abc got=%0d exp=0", abc1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done1); end
        checks++; if (tt_valid1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", tt_valid1); end
        rd_idx1 = 3'd7; #1;
        checks++; if (rd_row1 !== 4'd0) begin failures++; $display("[TB] FAIL reset_row7 got=%h exp=0", rd_row1); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy3 got=%b exp=0", busy3); end
    endtask

    task automatic test_full_scan;
        int n;
        logic [3:0] exp;
        $display("[TB] test_full_scan");
        fmode = 0;
        start1 = 1'b1; tick; start1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL scan_busy got=%b exp=1", busy1); end
        n = 0;
        do begin tick; n++; end while (!done1 && n < 40);
        checks++; if (n !== 16) begin failures++; $display("[TB] FAIL scan_latency got=%0d exp=16", n); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL scan_busy_done got=%b exp=0", busy1); end
        checks++; if (tt_valid1 !== 1'b0) begin failures++; $display("[TB] FAIL scan_valid_in_done got=%b exp=0", tt_valid1); end
        tick;
        checks++; if (done1 !== 1'b0) begin failures++; $display("[TB] FAIL scan_done_pulse got=%b exp=0", done1); end
        checks++; if (tt_valid1 !== 1'b1) begin failures++; $display("[TB] FAIL scan_valid got=%b exp=1", tt_valid1); end
        for (int i = 0; i < 8; i++) begin
            rd_idx1 = 3'(i); #1;
            exp = (i == 2 || i == 3) ? 4'b0001 : 4'b0000;
            checks++; if (rd_row1 !== exp) begin failures++; $display("[TB] FAIL scan_row%0d got=%h exp=%h", i, rd_row1, exp); end
        end
    endtask

    task automatic test_reset_mid_scan;
        $display("[TB] test_reset_mid_scan");
        start1 = 1'b1; tick; start1 = 1'b0;
        repeat (6) tick;
        checks++; if (abc1 !== 3'd3) begin failures++; $display("[TB] FAIL mid_abc got=%0d exp=3", abc1); end
        #2; rst_n = 1'b0; #1;
        checks++; if (abc1 !== 3'd0) begin failures++; $display("[TB] FAIL rst_abc got=%0d exp=0", abc1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy1); end
        rd_idx1 = 3'd2; #1;
        checks++; if (rd_row1 !== 4'd0) begin failures++; $display("[TB] FAIL rst_row2 got=%h exp=0", rd_row1); end
        tick; tick;
        rst_n = 1'b1;
        tick; tick;
        checks++; if (busy1 !== 1'b0 || abc1 !== 3'd0 || tt_valid1 !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_idle got busy=%b abc=%0d valid=%b exp 0/0/0", busy1, abc1, tt_valid1);
        end
    endtask

    task automatic test_abort;
        int dcount;
        logic [3:0] exp;
        $display("[TB] test_abort");
        fmode = 1;
        start1 = 1'b1; tick; start1 = 1'b0;
        repeat (10) tick;
        checks++; if (abc1 !== 3'd5 || busy1 !== 1'b1) begin
            failures++; $display("[TB] FAIL abort_pre got abc=%0d busy=%b exp 5/1", abc1, busy1);
        end
        abort1 = 1'b1; tick; abort1 = 1'b0;
        checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy1); end
        checks++; if (abc1 !== 3'd5) begin failures++; $display("[TB] FAIL abort_abc_hold got=%0d exp=5", abc1); end
        dcount = 0;
        for (int n = 0; n < 20; n++) begin
            if (done1 === 1'b1 || busy1 === 1'b1) dcount++;
            tick;
        end
        checks++; if (dcount !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", dcount); end
        checks++; if (tt_valid1 !== 1'b0) begin failures++; $display("[TB] FAIL abort_valid got=%b exp=0", tt_valid1); end
        for (int i = 0; i < 8; i++) begin
            rd_idx1 = 3'(i); #1;
            exp = (i < 5) ? {1'b1, 3'(i)} : 4'b0000;
            checks++; if (rd_row1 !== exp) begin failures++; $display("[TB] FAIL abort_row%0d got=%h exp=%h", i, rd_row1, exp); end
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        int extra;
        $display("[TB] test_start_while_busy");
        fmode = 0;
        start1 = 1'b1; tick; start1 = 1'b0;
        n = 0;
        do begin
            tick; n++;
            if (n == 5) start1 = 1'b1;
            if (n == 6) start1 = 1'b0;
        end while (!done1 && n < 40);
        checks++; if (n !== 16) begin failures++; $display("[TB] FAIL busy_start_latency got=%0d exp=16", n); end
        extra = 0;
        for (int k = 0; k < 25; k++) begin
            tick;
            if (done1 === 1'b1 || busy1 === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL busy_start_queued got=%0d exp=0", extra); end
        rd_idx1 = 3'd3; #1;
        checks++; if (rd_row1 !== 4'b0001) begin failures++; $display("[TB] FAIL busy_start_row3 got=%h exp=1", rd_row1); end
    endtask

    task automatic test_start_held;
        int dcount;
        $display("[TB] test_start_held");
        fmode = 0;
        start1 = 1'b1; tick;
        dcount = 0;
        for (int n = 1; n <= 60 && dcount < 3; n++) begin
            tick;
            if (n == 17) begin
                checks++; if (tt_valid1 !== 1'b1) begin failures++; $display("[TB] FAIL held_valid_gap got=%b exp=1", tt_valid1); end
            end
            if (n == 18 || n == 25) begin
                checks++; if (tt_valid1 !== 1'b0) begin failures++; $display("[TB] FAIL held_valid_scan n=%0d got=%b exp=0", n, tt_valid1); end
            end
            if (done1 === 1'b1) begin
                checks++; if (n !== 16 + 18 * dcount) begin
                    failures++; $display("[TB] FAIL held_done_pos got=%0d exp=%0d", n, 16 + 18 * dcount);
                end
                dcount++;
            end
        end
        start1 = 1'b0;
        checks++; if (dcount !== 3) begin failures++; $display("[TB] FAIL held_done_count got=%0d exp=3", dcount); end
        tick; tick;
        checks++; if (tt_valid1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++; $display("[TB] FAIL held_end got valid=%b busy=%b exp 1/0", tt_valid1, busy1);
        end
    endtask

    task automatic test_settle;
        int n;
        logic [3:0] exp_tab [8];
        $display("[TB] test_settle");
        exp_tab = '{4'h0, 4'hA, 4'hB, 4'h3, 4'h8, 4'h6, 4'h2, 4'hE};
        start3 = 1'b1; tick; start3 = 1'b0;
        n = 0;
        do begin tick; n++; end while (!done3 && n < 60);
        checks++; if (n !== 32) begin failures++; $display("[TB] FAIL settle_latency got=%0d exp=32", n); end
        tick;
        checks++; if (tt_valid3 !== 1'b1) begin failures++; $display("[TB] FAIL settle_valid got=%b exp=1", tt_valid3); end
        for (int i = 0; i < 8; i++) begin
            rd_idx3 = 3'(i); #1;
            checks++; if (rd_row3 !== exp_tab[i]) begin
                failures++; $display("[TB] FAIL settle_row%0d got=%h exp=%h", i, rd_row3, exp_tab[i]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start1  = 1'b0; abort1 = 1'b0; rd_idx1 = 3'd0;
        start3  = 1'b0; abort3 = 1'b0; rd_idx3 = 3'd0;
        fmode   = 0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        test_reset;
        test_full_scan;
        test_reset_mid_scan;
        test_abort;
        test_start_while_busy;
        test_start_held;
        test_settle;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
